act_pwl_unit: RTL

- Multi-channel, pipelined piecewise-linear activation unit for the neural-unit (NU) array outputs.
- Every beat takes one signed fixed-point value per channel, evaluates y = a[seg]*x + b[seg] using a runtime-programmable coefficient LUT, and returns the saturated result.
- It also supports bypass and ReLU modes.
- Sits between the NU accumulators and the output memory. One shared LUT serves all channels.

---
 rtl/act_pwl_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/act_pwl_unit.sv
// Multi-lane, three-stage piecewise-linear activation unit (y = a[seg]*x + b[seg]) with
// bypass and ReLU modes, sharing one runtime-programmable coefficient table across lanes.
module act_pwl_unit #(
  parameter int CHANNELS  = 4,
  parameter int Q_INT     = 4,
  parameter int Q_FRAC    = 12,
  parameter int LUT_DEPTH = 6,
  parameter int A_Q_INT   = 4,
  parameter int A_Q_FRAC  = 12,
  parameter int B_Q_INT   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [1:0]                          in_mode,
  input  logic [CHANNELS*(Q_INT+Q_FRAC)-1:0]  in_x,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [CHANNELS*(Q_INT+Q_FRAC)-1:0]  out_y,
  input  logic                                lut_we,
  input  logic [LUT_DEPTH-1:0]                lut_addr,
  input  logic [A_Q_INT+A_Q_FRAC-1:0]         lut_a,
  input  logic [B_Q_INT+Q_FRAC-1:0]           lut_b
);

  localparam int DW = Q_INT + Q_FRAC;
  localparam int AW = A_Q_INT + A_Q_FRAC;
  localparam int BW = B_Q_INT + Q_FRAC;
  localparam int PW = AW + DW;
  localparam int RW = PW + 1;
  localparam int NE = 1 << LUT_DEPTH;

  localparam logic [AW-1:0]        A_ONE = AW'(1) << A_Q_FRAC;
  localparam logic signed [RW-1:0] HALF  = RW'(1) <<< (A_Q_FRAC - 1);
  localparam logic signed [DW-1:0] Y_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] Y_MIN = {1'b1, {(DW-1){1'b0}}};

  logic [AW-1:0] lut_a_reg [NE];
  logic [BW-1:0] lut_b_reg [NE];

  logic       adv;
  logic       s1_valid_reg, s2_valid_reg, out_valid_reg;
  logic [1:0] s1_mode_reg, s2_mode_reg;

  // The table is flop-based: every lane reads a different entry in the same cycle,
  // and reset must restore the identity mapping in every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) begin
        lut_a_reg[i] <= A_ONE;
        lut_b_reg[i] <= '0;
      end
    end else if (lut_we) begin
      lut_a_reg[lut_addr] <= lut_a;
      lut_b_reg[lut_addr] <= lut_b;
    end
  end

  assign adv       = !out_valid_reg || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_reg;

  // Whole pipeline moves in lockstep; bubbles stay in place during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      s1_mode_reg   <= 2'd0;
      s2_mode_reg   <= 2'd0;
    end else if (adv) begin
      s1_valid_reg  <= in_valid;
      s1_mode_reg   <= in_mode;
      s2_valid_reg  <= s1_valid_reg;
      s2_mode_reg   <= s1_mode_reg;
      out_valid_reg <= s2_valid_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic signed [DW-1:0]    x_l;
      logic [LUT_DEPTH-1:0]    idx_l;
      logic signed [DW-1:0]    s1_x_reg, s2_x_reg, y_reg, y_next, pwl_y;
      logic signed [AW-1:0]    s1_a_reg;
      logic signed [BW-1:0]    s1_b_reg, s2_b_reg;
      logic signed [PW-1:0]    s2_p_reg;
      logic signed [RW-1:0]    rnd, sum;

      assign x_l   = in_x[gi*DW +: DW];
      // Offset-binary segment index: most negative x maps to entry 0
      assign idx_l = {~x_l[DW-1], x_l[DW-2 -: LUT_DEPTH-1]};

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_x_reg <= '0;
          s1_a_reg <= '0;
          s1_b_reg <= '0;
          s2_x_reg <= '0;
          s2_p_reg <= '0;
          s2_b_reg <= '0;
          y_reg    <= '0;
        end else if (adv) begin
          s1_x_reg <= x_l;
          s1_a_reg <= lut_a_reg[idx_l];
          s1_b_reg <= lut_b_reg[idx_l];
          s2_x_reg <= s1_x_reg;
          s2_p_reg <= PW'(s1_a_reg) * PW'(s1_x_reg);
          s2_b_reg <= s1_b_reg;
          y_reg    <= y_next;
        end
      end

      always_comb begin
        rnd   = (RW'(s2_p_reg) + HALF) >>> A_Q_FRAC;
        sum   = rnd + RW'(s2_b_reg);
        pwl_y = sum[DW-1:0];
        if (sum > RW'(Y_MAX)) begin
          pwl_y = Y_MAX;
        end else if (sum < RW'(Y_MIN)) begin
          pwl_y = Y_MIN;
        end
        y_next = s2_x_reg;
        case (s2_mode_reg)
          2'd1:    y_next = s2_x_reg[DW-1] ? '0 : s2_x_reg;
          2'd2:    y_next = pwl_y;
          default: y_next = s2_x_reg;
        endcase
      end

      assign out_y[gi*DW +: DW] = y_reg;
    end
  endgenerate

endmodule
